// File: rtl/ir_key_ctrl.sv
// NEC IR keypad-entry controller: validates frames, maps keys, and edits a
// six-digit BCD entry that is committed to o_value with a one-cycle strobe.
module ir_key_ctrl #(
    parameter logic [7:0]  NEC_ADDR    = 8'h00,
    parameter logic [31:0] TIMEOUT_CYC = 32'd250_000_000,
    parameter logic [31:0] BLINK_CYC   = 32'd12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    output logic [23:0] o_disp_num,
    output logic [5:0]  o_disp_dp,
    output logic [23:0] o_value,
    output logic        o_value_vld,
    output logic        o_err,
    output logic        o_edit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Command codes of digits 0..9, digit 0 in the low byte.
    localparam logic [79:0] DIGIT_CMDS = {
        8'h4A, 8'h52, 8'h42, 8'h5A, 8'h1C, 8'h08, 8'h5E, 8'h18, 8'h0C, 8'h16
    };
    localparam logic [7:0] CMD_BACKSPACE = 8'h44;
    localparam logic [7:0] CMD_CLEAR     = 8'h43;
    localparam logic [7:0] CMD_ENTER     = 8'h40;

    state_t      state_reg, state_next;
    logic [23:0] entry_reg, entry_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [23:0] value_reg, value_next;
    logic        value_vld_reg, value_vld_next;
    logic        err_reg, err_next;
    logic [23:0] disp_num_reg, disp_num_next;
    logic [5:0]  disp_dp_reg, disp_dp_next;
    logic        edit_reg, edit_next;
    logic [31:0] to_cnt_reg, to_cnt_next;
    logic [31:0] blink_cnt_reg, blink_cnt_next;
    logic        cursor_next;

    logic [7:0] frame_addr, frame_addr_n, frame_cmd, frame_cmd_n;
    logic       frame_ok, key_vld, bad_frame;
    logic [9:0] digit_hit;
    logic       is_digit, is_bs, is_clr, is_ent;
    logic [3:0] digit_val;

    assign frame_addr   = i_frame[31:24];
    assign frame_addr_n = i_frame[23:16];
    assign frame_cmd    = i_frame[15:8];
    assign frame_cmd_n  = i_frame[7:0];

    assign frame_ok  = (frame_addr == NEC_ADDR) && (frame_addr_n == ~frame_addr)
                    && (frame_cmd_n == ~frame_cmd);
    assign key_vld   = i_frame_vld && frame_ok;
    assign bad_frame = i_frame_vld && !frame_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_digit_match
            assign digit_hit[gi] = (frame_cmd == DIGIT_CMDS[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        digit_val = 4'h0;
        for (int i = 0; i < 10; i++) begin
            if (digit_hit[i]) begin
                digit_val = 4'(i);
            end
        end
    end

    assign is_digit = |digit_hit;
    assign is_bs    = (frame_cmd == CMD_BACKSPACE);
    assign is_clr   = (frame_cmd == CMD_CLEAR);
    assign is_ent   = (frame_cmd == CMD_ENTER);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            entry_reg     <= 24'h0;
            cnt_reg       <= 3'd0;
            value_reg     <= 24'h0;
            value_vld_reg <= 1'b0;
            err_reg       <= 1'b0;
            disp_num_reg  <= 24'h0;
            disp_dp_reg   <= 6'h0;
            edit_reg      <= 1'b0;
            to_cnt_reg    <= 32'd0;
            blink_cnt_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            entry_reg     <= entry_next;
            cnt_reg       <= cnt_next;
            value_reg     <= value_next;
            value_vld_reg <= value_vld_next;
            err_reg       <= err_next;
            disp_num_reg  <= disp_num_next;
            disp_dp_reg   <= disp_dp_next;
            edit_reg      <= edit_next;
            to_cnt_reg    <= to_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        entry_next     = entry_reg;
        cnt_next       = cnt_reg;
        value_next     = value_reg;
        value_vld_next = 1'b0;
        err_next       = 1'b0;
        to_cnt_next    = 32'd0;
        blink_cnt_next = 32'd0;
        cursor_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                err_next = bad_frame;
                if (key_vld) begin
                    if (is_digit) begin
                        entry_next  = {20'h0, digit_val};
                        cnt_next    = 3'd1;
                        state_next  = ST_EDIT;
                        cursor_next = 1'b1;
                    end else if (is_clr) begin
                        value_next     = 24'h0;
                        value_vld_next = 1'b1;
                    end
                end
            end

            ST_EDIT: begin
                err_next = bad_frame;
                if (blink_cnt_reg == BLINK_CYC - 32'd1) begin
                    blink_cnt_next = 32'd0;
                    cursor_next    = ~disp_dp_reg[0];
                end else begin
                    blink_cnt_next = blink_cnt_reg + 32'd1;
                    cursor_next    = disp_dp_reg[0];
                end

                // A valid key takes priority over a coincident expiry.
                to_cnt_next = to_cnt_reg + 32'd1;
                if (key_vld) begin
                    to_cnt_next = 32'd0;
                    if (is_digit) begin
                        if (cnt_reg == 3'd6) begin
                            err_next = 1'b1;
                        end else begin
                            entry_next = {entry_reg[19:0], digit_val};
                            cnt_next   = cnt_reg + 3'd1;
                        end
                    end else if (is_bs) begin
                        entry_next = {4'h0, entry_reg[23:4]};
                        cnt_next   = cnt_reg - 3'd1;
                        if (cnt_reg == 3'd1) begin
                            state_next = ST_IDLE;
                        end
                    end else if (is_clr) begin
                        state_next = ST_IDLE;
                        entry_next = 24'h0;
                        cnt_next   = 3'd0;
                    end else if (is_ent) begin
                        state_next     = ST_COMMIT;
                        value_next     = entry_reg;
                        value_vld_next = 1'b1;
                    end
                end else if (to_cnt_reg == TIMEOUT_CYC - 32'd1) begin
                    state_next = ST_IDLE;
                    entry_next = 24'h0;
                    cnt_next   = 3'd0;
                    err_next   = 1'b1;
                end
            end

            ST_COMMIT: begin
                state_next = ST_IDLE;
                entry_next = 24'h0;
                cnt_next   = 3'd0;
            end

            default: begin
                state_next = ST_IDLE;
                entry_next = 24'h0;
                cnt_next   = 3'd0;
            end
        endcase

        if (state_next != ST_EDIT) begin
            to_cnt_next    = 32'd0;
            blink_cnt_next = 32'd0;
            cursor_next    = 1'b0;
        end
    end

    // Display outputs are derived from next-state values so keys show after one edge.
    always_comb begin
        edit_next     = (state_next == ST_EDIT);
        disp_num_next = edit_next ? entry_next : value_next;
        disp_dp_next  = {5'b0, edit_next & cursor_next};
    end

    assign o_disp_num  = disp_num_reg;
    assign o_disp_dp   = disp_dp_reg;
    assign o_value     = value_reg;
    assign o_value_vld = value_vld_reg;
    assign o_err       = err_reg;
    assign o_edit      = edit_reg;

endmodule
